// File: rtl/uart_rsa_ctrl.sv
// uart_rsa_ctrl
// Sequencing controller between the UART byte receiver, the RSA decryption core
// and the UART byte transmitter.
//   - Collects N_BYTES received bytes MSB first into one ciphertext operand.
//   - Pulses o_Start to the core, then waits for i_Done.
//   - Streams the plaintext back out MSB first, one byte per transmitter
//     handshake (o_Tx_DV out, i_Tx_Done back, i_Tx_Active as backpressure).
// A partial operand is thrown away if the receiver goes quiet for
// TIMEOUT_CYCLES clocks. o_Err flags that for one cycle.
//
// Optional build macro: RSA_CTRL_SYNC_EN
//   Defined   - IDLE waits for the sync byte 8'hA5. The sync byte is not stored.
//               Every byte after it, including another 8'hA5, is operand data.
//   Undefined - the first byte received in IDLE is already operand data.

module uart_rsa_ctrl #(
    parameter int N_BYTES        = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_DV,
    input  logic [7:0]           i_Rx_Byte,
    output logic [8*N_BYTES-1:0] o_Cipher,
    output logic                 o_Start,
    input  logic                 i_Done,
    input  logic [8*N_BYTES-1:0] i_Plain,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic                 o_Err
);

    localparam int W     = 8 * N_BYTES;
    localparam int CNT_W = $clog2(N_BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef RSA_CTRL_SYNC_EN
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_START,
        S_WAIT_CORE,
        S_LOAD_TX,
        S_WAIT_TX
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] rx_count_next;
    logic [TMO_W-1:0] tmo_count;
    logic [TMO_W-1:0] tmo_count_next;
    logic [W-1:0]     shift_reg;
    logic [W-1:0]     shift_reg_next;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] tx_count_next;

    logic [W-1:0]     cipher_next;
    logic             start_next;
    logic             tx_dv_next;
    logic [7:0]       tx_byte_next;
    logic             err_next;

    // The core and the transmitter only need to know if a job is in flight.
    assign o_Busy = (state != S_IDLE);

    // State register and all registered outputs. Reset aborts any job in progress.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= S_IDLE;
            rx_count  <= '0;
            tmo_count <= '0;
            shift_reg <= '0;
            tx_count  <= '0;
            o_Cipher  <= '0;
            o_Start   <= 1'b0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
            o_Err     <= 1'b0;
        end else begin
            state     <= state_next;
            rx_count  <= rx_count_next;
            tmo_count <= tmo_count_next;
            shift_reg <= shift_reg_next;
            tx_count  <= tx_count_next;
            o_Cipher  <= cipher_next;
            o_Start   <= start_next;
            o_Tx_DV   <= tx_dv_next;
            o_Tx_Byte <= tx_byte_next;
            o_Err     <= err_next;
        end
    end

    // Next-state and next-output logic. Strobes default low and data holds its value.
    always_comb begin
        state_next     = state;
        rx_count_next  = rx_count;
        tmo_count_next = tmo_count;
        shift_reg_next = shift_reg;
        tx_count_next  = tx_count;
        cipher_next    = o_Cipher;
        start_next     = 1'b0;
        tx_dv_next     = 1'b0;
        tx_byte_next   = o_Tx_Byte;
        err_next       = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_Rx_DV) begin
`ifdef RSA_CTRL_SYNC_EN
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        rx_count_next  = '0;
                        tmo_count_next = '0;
                        state_next     = S_COLLECT;
                    end
`else
                    cipher_next    = (o_Cipher << 8) | W'(i_Rx_Byte);
                    rx_count_next  = CNT_W'(1);
                    tmo_count_next = '0;
                    state_next     = (N_BYTES == 1) ? S_START : S_COLLECT;
`endif
                end
            end

            S_COLLECT: begin
                if (tmo_count == TMO_LAST) begin
                    err_next       = 1'b1;
                    cipher_next    = '0;
                    rx_count_next  = '0;
                    tmo_count_next = '0;
                    state_next     = S_IDLE;
                end else if (i_Rx_DV) begin
                    cipher_next    = (o_Cipher << 8) | W'(i_Rx_Byte);
                    rx_count_next  = rx_count + CNT_W'(1);
                    tmo_count_next = '0;
                    if (rx_count_next == CNT_LAST) begin
                        state_next = S_START;
                    end
                end else begin
                    tmo_count_next = tmo_count + TMO_W'(1);
                end
            end

            S_START: begin
                start_next = 1'b1;
                state_next = S_WAIT_CORE;
            end

            S_WAIT_CORE: begin
                if (i_Done) begin
                    shift_reg_next = i_Plain;
                    tx_count_next  = '0;
                    state_next     = S_LOAD_TX;
                end
            end

            S_LOAD_TX: begin
                if (!i_Tx_Active) begin
                    tx_byte_next = shift_reg[W-1 -: 8];
                    tx_dv_next   = 1'b1;
                    state_next   = S_WAIT_TX;
                end
            end

            S_WAIT_TX: begin
                if (i_Tx_Done) begin
                    shift_reg_next = shift_reg << 8;
                    tx_count_next  = tx_count + CNT_W'(1);
                    if (tx_count_next == CNT_LAST) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_LOAD_TX;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
